// File: rtl/blink_period_meter_if.sv
`default_nettype none
// ============================================================================
// Module   : blink_period_meter_if
// Purpose  : Bundles the blink input and all measurement results of
//            blink_period_meter into one interface.
// Modports : master - the meter (consumes blink_in, drives results)
//            slave  - the consumer / pin driver (drives blink_in, reads results)
// Signals  : blink_in, level, edge_rise, edge_fall, period[CNT_W],
//            period_valid, stalled
//            (+ high_time[CNT_W], high_valid when BLINK_PERIOD_METER_DUTY_EN)
// Options  : `define BLINK_PERIOD_METER_DUTY_EN adds the high-time outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface blink_period_meter_if #(
  parameter int CNT_W = 32
);
  logic             blink_in;
  logic             level;
  logic             edge_rise;
  logic             edge_fall;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             stalled;
`ifdef BLINK_PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] high_time;
  logic             high_valid;

  modport master (input  blink_in,
                  output level, edge_rise, edge_fall, period, period_valid,
                         stalled, high_time, high_valid);
  modport slave  (output blink_in,
                  input  level, edge_rise, edge_fall, period, period_valid,
                         stalled, high_time, high_valid);
`else
  modport master (input  blink_in,
                  output level, edge_rise, edge_fall, period, period_valid,
                         stalled);
  modport slave  (output blink_in,
                  input  level, edge_rise, edge_fall, period, period_valid,
                         stalled);
`endif
endinterface
`default_nettype wire

// File: rtl/blink_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : blink_period_meter
// Purpose  : Synchronizes and debounces a slow blink/square-wave input,
//            measures the period between filtered rising edges in clk cycles
//            and flags loss of activity.
// Ports    : clk   - clock (same slow domain as the blinker)
//            rst_n - asynchronous active-low reset
//            bus   - blink_period_meter_if.master
//                    blink_in (in), level, edge_rise, edge_fall, period,
//                    period_valid, stalled (+ high_time, high_valid)
// Options  : `define BLINK_PERIOD_METER_DUTY_EN adds high_time/high_valid:
//            cycles from a filtered rising edge to the following falling edge.
// Note     : the interface CNT_W must match this module's CNT_W.
// Revision : 1.0 - initial release
// ============================================================================
module blink_period_meter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 32,
  parameter int TIMEOUT         = 66000
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  blink_period_meter_if.master  bus
);

  localparam int               c_dbw     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_dbw-1:0] c_db_last = c_dbw'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_dbw-1:0] c_db_one  = c_dbw'(1);
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_STALLED = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronizer and debounce filter
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_dbw-1:0]       r_db_cnt;
  logic                   r_level;
  logic                   r_edge_rise;
  logic                   r_edge_fall;
  logic                   w_s;
  logic                   w_flip;
  logic                   w_rise;
  logic                   w_fall;

  assign w_s    = r_sync[SYNC_STAGES-1];
  // The filtered level changes on the DEBOUNCE_CYCLES-th consecutive
  // disagreeing sample; w_rise/w_fall mark the cycle this happens so the
  // period logic acts in the same cycle edge_rise is registered.
  assign w_flip = (w_s != r_level) && (r_db_cnt == c_db_last);
  assign w_rise = w_flip &&  w_s;
  assign w_fall = w_flip && !w_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= '0;
      r_db_cnt    <= '0;
      r_level     <= 1'b0;
      r_edge_rise <= 1'b0;
      r_edge_fall <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.blink_in};
      r_edge_rise <= w_rise;
      r_edge_fall <= w_fall;
      if (w_s == r_level) begin
        r_db_cnt <= '0;
      end else if (w_flip) begin
        r_level  <= w_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + c_db_one;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Period measurement FSM
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_nxt;
  logic             r_period_valid;
  logic             w_period_valid_nxt;
  logic             r_stalled;
  logic             w_stalled_nxt;
`ifdef BLINK_PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] r_high_time;
  logic [CNT_W-1:0] w_high_time_nxt;
  logic             r_high_valid;
  logic             w_high_valid_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_stalled      <= 1'b0;
`ifdef BLINK_PERIOD_METER_DUTY_EN
      r_high_time    <= '0;
      r_high_valid   <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_period       <= w_period_nxt;
      r_period_valid <= w_period_valid_nxt;
      r_stalled      <= w_stalled_nxt;
`ifdef BLINK_PERIOD_METER_DUTY_EN
      r_high_time    <= w_high_time_nxt;
      r_high_valid   <= w_high_valid_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = (r_cnt == c_timeout) ? r_cnt : r_cnt + c_one;
    w_period_nxt       = r_period;
    w_period_valid_nxt = 1'b0;
    w_stalled_nxt      = r_stalled;

    // cnt counts the current edge_rise cycle as 1, so its value just before
    // the next rising edge equals the edge-to-edge distance.
    if (w_rise) begin
      w_cnt_nxt = c_one;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // A rising edge takes priority over a timeout in the same cycle.
        if (w_rise) begin
          w_period_nxt       = r_cnt;
          w_period_valid_nxt = 1'b1;
        end else if (r_cnt == c_timeout) begin
          w_state_nxt   = ST_STALLED;
          w_stalled_nxt = 1'b1;
        end
      end
      ST_STALLED: begin
        // Re-arm only: the gap since the last edge is not a valid period.
        if (w_rise) begin
          w_state_nxt   = ST_ARMED;
          w_stalled_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_stalled_nxt = 1'b0;
      end
    endcase
  end

`ifdef BLINK_PERIOD_METER_DUTY_EN
  // High time is the cnt value at the falling edge; cnt already saturates.
  always_comb begin
    w_high_valid_nxt = (r_state == ST_ARMED) && w_fall;
    w_high_time_nxt  = w_high_valid_nxt ? r_cnt : r_high_time;
  end

  assign bus.high_time  = r_high_time;
  assign bus.high_valid = r_high_valid;
`endif

  assign bus.level        = r_level;
  assign bus.edge_rise    = r_edge_rise;
  assign bus.edge_fall    = r_edge_fall;
  assign bus.period       = r_period;
  assign bus.period_valid = r_period_valid;
  assign bus.stalled      = r_stalled;

endmodule
`default_nettype wire

// File: doc/blink_period_meter.md
Name: blink_period_meter

Overview:
- Receive-side counterpart of the LFOSC LED blinker: samples an external blink/square-wave input and measures its period in clk cycles.
- Flags loss of activity.
- Used on the iCE40 board to check a blink source fed back through a pin, or any slow toggling input, against the expected ~1 Hz divider rate.
- Runs in the same slow internal-oscillator clock domain as the blinker.

Parameters:
- SYNC_STAGES, 2, metastability synchronizer depth on blink_in (min 2).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the filtered level changes (min 1).
- CNT_W, 32, width of the period counter and period output.
- TIMEOUT, 66000, cycles since the last rising edge after which the input is declared stalled (must be < 2^CNT_W).

Ports:
- clk  input  1  clock; the port is named clk as in the rest of the design.
- rst_n  input  1  reset; asynchronous, active-low.
- blink_in  input  1  asynchronous blink signal from pin.
- level  output  1  synchronized, debounced input level.
- edge_rise  output  1  one-cycle pulse on a filtered rising edge.
- edge_fall  output  1  one-cycle pulse on a filtered falling edge.
- period  output  CNT_W  cycles between the last two filtered rising edges.
- period_valid  output  1  one-cycle pulse when period is updated.
- stalled  output  1  high while no rising edge has occurred within TIMEOUT cycles.

Behaviour:
- Reset (async on rst_n low): sync flops 0, level 0, edge_rise 0, edge_fall 0, period 0, period_valid 0, stalled 0, debounce counter 0, period counter 0, FSM=IDLE. Outputs are registered and take their reset values immediately.
- Sync: blink_in passes through a SYNC_STAGES flop chain; call the last stage s.
- Debounce:
  - If s == level: debounce counter <= 0.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1 while s != level, level <= s and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes level.
- Edges: edge_rise or edge_fall is registered high in the same cycle level changes (0->1 or 1->0), low otherwise.
- Latency: a blink_in change held stable shows on level/edge_* exactly SYNC_STAGES+DEBOUNCE_CYCLES rising clk edges later.
- Period counter cnt:
  - Loads 1 on an edge_rise cycle; increments every other cycle.
  - Saturates at TIMEOUT.
  - period = (cycle of edge_rise N) - (cycle of edge_rise N-1).
- FSM states: IDLE, ARMED, STALLED.
  - IDLE: on a filtered rising edge -> ARMED, cnt<=1, no period output.
  - ARMED, filtered rising edge: period <= cnt, period_valid pulses 1 cycle, cnt<=1, stay ARMED.
  - ARMED, cnt == TIMEOUT with no edge: -> STALLED, stalled<=1.
  - STALLED: on a filtered rising edge -> ARMED, stalled<=0, cnt<=1. Re-arm only; period_valid does not fire and period holds its last value.
- Simultaneous rising edge and cnt == TIMEOUT: the edge wins. Period is reported as TIMEOUT and the FSM stays ARMED.
- Falling edges never affect the FSM or cnt.
- period holds its value between updates.
- rst_n asserted mid-measurement discards the partial count. The first edge after reset only arms the FSM.

Optional Feature:
- Macro: BLINK_PERIOD_METER_DUTY_EN.
- Defined:
  - Adds output high_time (CNT_W): cycles from the last filtered rising edge to the following falling edge.
  - Updated on edge_fall while ARMED, reset 0, saturates at TIMEOUT.
  - Adds output high_valid, a one-cycle pulse coinciding with the update.
- Undefined: neither port exists; no extra logic.

Test Plan:
All tests use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, TIMEOUT=200.
1. Reset, then blink_in held 0 for 50 cycles -> level=0, no edge pulses, stalled=0, period=0, period_valid never asserts.
2. blink_in rises at cycle 10 and stays high -> edge_rise pulses at cycle 16 (latency 6), level=1 from cycle 16, no period_valid.
3. Square wave of period 40 cycles (20 high/20 low) -> period_valid every 40 cycles starting at the second edge_rise, period=40. With the macro defined, high_time=20.
4. 2-cycle and 3-cycle high glitches on a low blink_in -> level stays 0 and no edge pulses. A 4-cycle pulse -> exactly one edge_rise and one edge_fall.
5. After two edges 40 apart, blink_in held low -> stalled=1 exactly 200 cycles after the last edge_rise and period holds 40. The next rise clears stalled without period_valid; the rise after that reports the correct period.
6. rst_n pulsed low mid-period (async, between clk edges) -> all outputs return to reset values immediately. The next two rising edges produce a single period_valid with the correct period.
